// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and default sizing for the branch resolve queue.
// The queue holds predicted branches until they resolve in order.
package branch_resolve_queue_pkg;

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned PC_W_DEF  = 10;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACTIVE,
    ST_FLUSH
  } brq_state_e;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic                pred;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// Circular entry store for the branch resolve queue.
// It holds the head and tail pointers and the occupancy count, and a flush empties it.
module brq_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter type entry_t = brq_entry_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 head_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail] <= push_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_entry = mem[head];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue: it trains the predictor on every resolve.
// On a mispredict it flushes every younger in-flight branch.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PC_W  = PC_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alloc_valid,
  input  logic [PC_W-1:0]        alloc_pc,
  input  logic                   alloc_pred,
  output logic                   alloc_ready,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  output logic                   upd_valid,
  output logic [PC_W-1:0]        upd_pc,
  output logic                   upd_taken,
  output logic                   mispredict,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             mispred_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Same layout as brq_entry_t, sized to this instance's PC width.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
  } entry_t;

  brq_state_e    state;
  brq_state_e    state_next;
  entry_t        head_entry;
  entry_t        alloc_entry;
  logic          can_resolve;
  logic          mis;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;

  always_comb begin
    state_next  = state;
    alloc_ready = (state != ST_FLUSH) && (count < CW'(DEPTH));
    can_resolve = resolve_valid && (count != '0) && (state != ST_FLUSH);
    mis         = can_resolve && (resolve_taken != head_entry.pred);
    // A wrong-path allocation racing a mispredict must not survive the flush.
    push        = alloc_valid && alloc_ready && !mis;
    pop         = can_resolve && !mis;
    alloc_entry = '{pc: alloc_pc, pred: alloc_pred};
    count_next  = count + CW'(push) - CW'(pop);
    unique case (state)
      ST_FLUSH: state_next = ST_EMPTY;
      default: begin
        if (mis) begin
          state_next = ST_FLUSH;
        end else if (count_next == '0) begin
          state_next = ST_EMPTY;
        end else begin
          state_next = ST_ACTIVE;
        end
      end
    endcase
  end

  brq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (alloc_entry),
    .pop        (pop),
    .flush      (mis),
    .head_entry (head_entry),
    .count      (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_EMPTY;
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      mispred_cnt <= '0;
    end else begin
      state      <= state_next;
      upd_valid  <= can_resolve;
      mispredict <= mis;
      if (can_resolve) begin
        upd_pc    <= head_entry.pc;
        upd_taken <= resolve_taken;
      end
      if (mis && (mispred_cnt != 8'hFF)) begin
        mispred_cnt <= mispred_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: it runs directed and random traffic.
// Each step is checked against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PC_W  = 10;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   alloc_valid = 1'b0;
  logic [PC_W-1:0]        alloc_pc = '0;
  logic                   alloc_pred = 1'b0;
  logic                   alloc_ready;
  logic                   resolve_valid = 1'b0;
  logic                   resolve_taken = 1'b0;
  logic                   upd_valid;
  logic [PC_W-1:0]        upd_pc;
  logic                   upd_taken;
  logic                   mispredict;
  logic [$clog2(DEPTH):0] count;
  logic [7:0]             mispred_cnt;

  branch_resolve_queue #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .alloc_valid   (alloc_valid),
    .alloc_pc      (alloc_pc),
    .alloc_pred    (alloc_pred),
    .alloc_ready   (alloc_ready),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .mispredict    (mispredict),
    .count         (count),
    .mispred_cnt   (mispred_cnt)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: in-flight branches in program order.
  typedef struct {
    logic [PC_W-1:0] pc;
    bit              pred;
  } ent_t;

  ent_t            q[$];
  bit              m_known = 1'b0;
  bit              m_flush = 1'b0;
  bit              m_uv = 1'b0;
  bit              m_ut = 1'b0;
  bit              m_mis = 1'b0;
  logic [PC_W-1:0] m_pc = '0;
  int unsigned     m_mcnt = 0;

  task automatic step(input bit r, input bit av, input logic [PC_W-1:0] pc, input bit pd,
                      input bit rv, input bit rt);
    bit ready;
    bit res;
    bit mis;
    reset         = r;
    alloc_valid   = av;
    alloc_pc      = pc;
    alloc_pred    = pd;
    resolve_valid = rv;
    resolve_taken = rt;
    #1;
    ready = !m_flush && (q.size() < DEPTH);
    if (m_known) check("alloc_ready", 32'(alloc_ready), 32'(ready));
    @(posedge clock);
    if (r) begin
      q.delete();
      m_flush = 1'b0;
      m_uv    = 1'b0;
      m_ut    = 1'b0;
      m_mis   = 1'b0;
      m_pc    = '0;
      m_mcnt  = 0;
      m_known = 1'b1;
    end else begin
      res     = rv && (q.size() > 0) && !m_flush;
      mis     = 1'b0;
      m_flush = 1'b0;
      m_uv    = res;
      m_mis   = 1'b0;
      if (res) begin
        m_pc = q[0].pc;
        m_ut = rt;
        mis  = (rt != q[0].pred);
        if (mis) begin
          q.delete();
          m_flush = 1'b1;
          m_mis   = 1'b1;
          if (m_mcnt < 255) m_mcnt++;
        end else begin
          void'(q.pop_front());
        end
      end
      if (!mis && av && ready) q.push_back('{pc, pd});
    end
    #1;
    if (m_known) begin
      check("upd_valid", 32'(upd_valid), 32'(m_uv));
      check("upd_pc", 32'(upd_pc), 32'(m_pc));
      check("upd_taken", 32'(upd_taken), 32'(m_ut));
      check("mispredict", 32'(mispredict), 32'(m_mis));
      check("count", 32'(count), q.size());
      check("mispred_cnt", 32'(mispred_cnt), m_mcnt);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (4) step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_count", 32'(count), 0);
    check("rst_upd_valid", 32'(upd_valid), 0);

    // Single correct resolve.
    step(1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0);
    check("t1_count_one", 32'(count), 1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("t1_upd", {upd_valid, upd_taken, mispredict}, 32'b110);
    idle();

    // Fill to DEPTH, drop the overflow, resolve the oldest.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 10'(i), 1'b0, 1'b0, 1'b0);
    check("t2_full_count", 32'(count), 8);
    step(1'b0, 1'b1, 10'd9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t2_upd_pc", 32'(upd_pc), 1);
    check("t2_count_seven", 32'(count), 7);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle();

    // Mispredict flush; allocation and resolve during FLUSH are ignored.
    for (int i = 3; i <= 5; i++) step(1'b0, 1'b1, 10'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 10'd6, 1'b1, 1'b1, 1'b0);
    check("t3_upd_pc", 32'(upd_pc), 3);
    check("t3_count_zero", 32'(count), 0);
    step(1'b0, 1'b1, 10'd7, 1'b1, 1'b1, 1'b1);
    idle();

    // Simultaneous alloc + correct resolve across pointer wrap.
    step(1'b0, 1'b1, 10'd40, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 10'd41, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 10'(9 + i), i[0], 1'b1, q[0].pred);
    check("t4_count_two", 32'(count), 2);
    while (q.size() > 0) step(1'b0, 1'b0, '0, 1'b0, 1'b1, q[0].pred);

    // Resolve on empty, then saturate the mispredict counter.
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 10'(i), 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
      idle();
    end
    check("t5_sat", 32'(mispred_cnt), 255);

    // Random traffic, mostly-correct resolves, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      bit rt;
      rt = (q.size() > 0 && $urandom_range(0, 99) < 85) ? q[0].pred : 1'($urandom);
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 60, 10'($urandom), 1'($urandom),
           $urandom_range(0, 99) < 40, rt);
    end

    // Reset mid-stream with five in flight.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 10'(100 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 10'(200 + i), 1'b0, 1'b0, 1'b0);
    check("t6_count_five", 32'(count), 5);
    step(1'b1, 1'b1, 10'd300, 1'b1, 1'b1, 1'b1);
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_upd_valid", 32'(upd_valid), 0);
    check("t6_rst_mcnt", 32'(mispred_cnt), 0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
